// File: rtl/ex_commit_wb_pkg.sv
// rtl/ex_commit_wb_pkg.sv - shared types and constants for the commit/writeback stage
package raisin64_commit_pkg;

    localparam logic [5:0] REG_ZERO = 6'd0;

    typedef struct packed {
        logic [63:0] out;
        logic [63:0] out2;
        logic [5:0]  rd_rn;
        logic [5:0]  rd2_rn;
    } commit_entry_t;

    typedef enum logic {
        PH_RD,
        PH_RD2
    } drain_phase_t;

endpackage

// File: rtl/ex_commit_wb_if.sv
// rtl/ex_commit_wb_if.sv - execute-result and register-file write port bundle
interface ex_commit_wb_if;

    logic        in_valid;
    logic [63:0] in_out;
    logic [63:0] in_out2;
    logic [5:0]  in_rd_rn;
    logic [5:0]  in_rd2_rn;
    logic        stall;
    logic        rf_we;
    logic [5:0]  rf_wa;
    logic [63:0] rf_wd;
    logic        rf_ready;
    logic        retire;

    modport master (
        output in_valid, in_out, in_out2, in_rd_rn, in_rd2_rn, rf_ready,
        input  stall, rf_we, rf_wa, rf_wd, retire
    );

    modport slave (
        input  in_valid, in_out, in_out2, in_rd_rn, in_rd2_rn, rf_ready,
        output stall, rf_we, rf_wa, rf_wd, retire
    );

endinterface

// File: rtl/ex_commit_wb_fifo.sv
// rtl/ex_commit_wb_fifo.sv - result FIFO; only pointers and count are reset
module commit_fifo
    import raisin64_commit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  commit_entry_t push_data,
    input  logic          pop,
    output commit_entry_t head,
    output logic [AW:0]   count
);

    commit_entry_t     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && push && count == (AW+1)'(DEPTH)) begin
            $error("commit_fifo: push while full, FIFO state undefined");
        end
    end
`endif

endmodule

// File: rtl/ex_commit_wb.sv
// rtl/ex_commit_wb.sv - buffers execute results and drains them onto one register-file write port
module ex_commit_wb
    import raisin64_commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    ex_commit_wb_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    commit_entry_t push_data;
    commit_entry_t head;
    logic [AW:0]   count;
    logic          pop;
    drain_phase_t  phase_q;
    drain_phase_t  phase_d;
    drain_phase_t  phase_eff;
    logic          we;
    logic [5:0]    wa;
    logic [63:0]   wd;
    logic          retire;

    assign push_data = '{out:    bus.in_out,
                         out2:   bus.in_out2,
                         rd_rn:  bus.in_rd_rn,
                         rd2_rn: bus.in_rd2_rn};

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.in_valid),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // One slot stays free for the result the execute stage already has in flight.
    assign bus.stall = (count >= (AW+1)'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_RD;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        pop       = 1'b0;
        retire    = 1'b0;
        we        = 1'b0;
        wa        = REG_ZERO;
        wd        = '0;
        phase_d   = phase_q;
        phase_eff = phase_q;
        if (count != '0) begin
            // An entry with no primary destination skips straight to its secondary write.
            if (phase_q == PH_RD && head.rd_rn == REG_ZERO && head.rd2_rn != REG_ZERO) begin
                phase_eff = PH_RD2;
            end
            case (phase_eff)
                PH_RD: begin
                    if (head.rd_rn != REG_ZERO) begin
                        we = 1'b1;
                        wa = head.rd_rn;
                        wd = head.out;
                        if (bus.rf_ready) begin
                            if (head.rd2_rn != REG_ZERO) begin
                                phase_d = PH_RD2;
                            end else begin
                                pop    = 1'b1;
                                retire = 1'b1;
                            end
                        end
                    end else begin
                        pop    = 1'b1;
                        retire = 1'b1;
                    end
                end
                PH_RD2: begin
                    we = 1'b1;
                    wa = head.rd2_rn;
                    wd = head.out2;
                    if (bus.rf_ready) begin
                        pop     = 1'b1;
                        retire  = 1'b1;
                        phase_d = PH_RD;
                    end else begin
                        phase_d = PH_RD2;
                    end
                end
                default: phase_d = PH_RD;
            endcase
        end else begin
            phase_d = PH_RD;
        end
    end

    assign bus.rf_we  = we;
    assign bus.rf_wa  = wa;
    assign bus.rf_wd  = wd;
    assign bus.retire = retire;

endmodule

// File: tb/tb_ex_commit_wb.sv
// tb/tb_ex_commit_wb.sv - scoreboard bench for ex_commit_wb
module tb_ex_commit_wb;
    import raisin64_commit_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [63:0] wd;
        logic        retire;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst;
    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    ex_commit_wb_if bus ();

    ex_commit_wb #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_push(input logic [5:0] rd, input logic [63:0] out,
                              input logic [5:0] rd2, input logic [63:0] out2);
        if (rd != 6'd0)   exp_q.push_back('{we: 1'b1, wa: rd,  wd: out,  retire: (rd2 == 6'd0)});
        if (rd2 != 6'd0)  exp_q.push_back('{we: 1'b1, wa: rd2, wd: out2, retire: 1'b1});
        if (rd == 6'd0 && rd2 == 6'd0)
            exp_q.push_back('{we: 1'b0, wa: 6'd0, wd: 64'd0, retire: 1'b1});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [5:0] rd, input logic [63:0] out,
                              input logic [5:0] rd2, input logic [63:0] out2);
        bus.in_valid  = 1'b1;
        bus.in_rd_rn  = rd;
        bus.in_out    = out;
        bus.in_rd2_rn = rd2;
        bus.in_out2   = out2;
        model_push(rd, out, rd2, out2);
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && ((bus.rf_we && bus.rf_ready) || bus.retire)) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_beat", {bus.rf_we, bus.retire}, 2'b00);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check_eq("sb_we",     bus.rf_we,  e.we);
                check_eq("sb_wa",     bus.rf_wa,  e.wa);
                check_eq("sb_wd",     bus.rf_wd,  e.wd);
                check_eq("sb_retire", bus.retire, e.retire);
            end
        end
    end

    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_out    = '0;
        bus.in_out2   = '0;
        bus.in_rd_rn  = '0;
        bus.in_rd2_rn = '0;
        bus.rf_ready  = 1'b1;
        step();
        step();
        check_eq("rst_stall",  bus.stall,  1'b0);
        check_eq("rst_rf_we",  bus.rf_we,  1'b0);
        check_eq("rst_rf_wa",  bus.rf_wa,  6'd0);
        check_eq("rst_rf_wd",  bus.rf_wd,  64'd0);
        check_eq("rst_retire", bus.retire, 1'b0);
        rst = 1'b0;
        step();

        // reset in the middle of a dual-destination drain
        push_entry(6'd5, 64'h11, 6'd6, 64'h22);
        @(negedge clk);
        check_eq("md_first_wa", bus.rf_wa, 6'd5);
        step();
        check_eq("md_ph_rd2_wa", bus.rf_wa, 6'd6);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_eq("md_rf_we",  bus.rf_we,  1'b0);
        check_eq("md_rf_wa",  bus.rf_wa,  6'd0);
        check_eq("md_rf_wd",  bus.rf_wd,  64'd0);
        check_eq("md_retire", bus.retire, 1'b0);
        check_eq("md_stall",  bus.stall,  1'b0);
        step();
        rst = 1'b0;
        push_entry(6'd2, 64'h33, 6'd0, 64'h0);
        @(negedge clk);
        check_eq("md_after_we", bus.rf_we, 1'b1);
        check_eq("md_after_wa", bus.rf_wa, 6'd2);
        step();

        // single destination: t+1 write and retire, t+2 idle
        push_entry(6'd3, 64'hDEAD_BEEF, 6'd0, 64'h0);
        @(negedge clk);
        check_eq("single_we",     bus.rf_we,  1'b1);
        check_eq("single_wa",     bus.rf_wa,  6'd3);
        check_eq("single_wd",     bus.rf_wd,  64'hDEAD_BEEF);
        check_eq("single_retire", bus.retire, 1'b1);
        @(negedge clk);
        check_eq("single_idle",   bus.rf_we,  1'b0);
        step();

        // dual destination
        push_entry(6'd4, 64'h1, 6'd9, 64'h2);
        @(negedge clk);
        check_eq("dual1_wa",     bus.rf_wa,  6'd4);
        check_eq("dual1_retire", bus.retire, 1'b0);
        @(negedge clk);
        check_eq("dual2_wa",     bus.rf_wa,  6'd9);
        check_eq("dual2_wd",     bus.rf_wd,  64'h2);
        check_eq("dual2_retire", bus.retire, 1'b1);
        @(negedge clk);
        check_eq("dual_idle",    bus.rf_we,  1'b0);
        step();

        // rd=0 entries
        push_entry(6'd0, 64'h0, 6'd7, 64'h55);
        @(negedge clk);
        check_eq("rd0_wa",     bus.rf_wa,  6'd7);
        check_eq("rd0_wd",     bus.rf_wd,  64'h55);
        check_eq("rd0_retire", bus.retire, 1'b1);
        step();
        push_entry(6'd0, 64'h0, 6'd0, 64'h0);
        @(negedge clk);
        check_eq("none_we",     bus.rf_we,  1'b0);
        check_eq("none_retire", bus.retire, 1'b1);
        step();
        wait_drain("drain_directed");

        // back-pressure: fill until stall, then one in-flight push
        bus.rf_ready = 1'b0;
        n = 0;
        while (!bus.stall && n < 10) begin
            push_entry(6'(10 + n), 64'(16'hA000 + n), 6'd0, 64'h0);
            n++;
        end
        check_eq("bp_pushes_to_stall", 64'(n), 64'(DEPTH - 1));
        push_entry(6'd20, 64'hA0FF, 6'd0, 64'h0);
        check_eq("bp_stall_full", bus.stall, 1'b1);
        @(negedge clk);
        check_eq("bp_hold_we", bus.rf_we, 1'b1);
        check_eq("bp_hold_wa", bus.rf_wa, 6'd10);
        step();
        step();
        check_eq("bp_no_drain", 64'(exp_q.size()), 64'(DEPTH));
        bus.rf_ready = 1'b1;
        wait_drain("bp_drain");
        step();
        check_eq("bp_stall_low", bus.stall, 1'b0);

        // push and pop together at count==DEPTH-1 across pointer wrap
        bus.rf_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) push_entry(6'(30 + i), 64'(16'hB000 + i), 6'd0, 64'h0);
        check_eq("pp_stall_pre", bus.stall, 1'b1);
        bus.rf_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_entry(6'(40 + i), 64'(16'hC000 + i), 6'd0, 64'h0);
            check_eq("pp_stall_hold", bus.stall, 1'b1);
        end
        check_eq("pp_queue_depth", 64'(exp_q.size()), 64'(DEPTH - 1));
        wait_drain("pp_drain");

        // mixed traffic with random back-pressure
        for (int i = 0; i < 60; i++) begin
            bus.rf_ready = ($urandom_range(0, 3) != 0);
            if (!bus.stall && $urandom_range(0, 1) == 1)
                push_entry(($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                           {$urandom, $urandom},
                           ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                           {$urandom, $urandom});
            else
                step();
        end
        bus.rf_ready = 1'b1;
        wait_drain("rand_drain");
        step();
        check_eq("final_idle_we", bus.rf_we, 1'b0);
        check_eq("final_stall",   bus.stall, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
